// File: rtl/parc_mem_arb3.sv
// parc_mem_arb3: round-robin arbiter sharing one memory port among three requesters,
// with in-order response routing through a tag FIFO of granted port ids.
`default_nettype none

module parc_mem_arb3 #(
  parameter int p_addr_sz         = 32,
  parameter int p_data_sz         = 32,
  parameter int p_max_outstanding = 4,
  localparam int c_len_sz = $clog2(p_data_sz/8),
  localparam int c_rq_sz  = 1 + p_addr_sz + c_len_sz + p_data_sz,
  localparam int c_rs_sz  = 1 + c_len_sz + p_data_sz,
  localparam int c_ptr_sz = $clog2(p_max_outstanding),
  localparam int c_cnt_sz = c_ptr_sz + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_val,
  output logic                req0_rdy,
  input  logic [c_rq_sz-1:0]  req0_msg,
  input  logic                req1_val,
  output logic                req1_rdy,
  input  logic [c_rq_sz-1:0]  req1_msg,
  input  logic                req2_val,
  output logic                req2_rdy,
  input  logic [c_rq_sz-1:0]  req2_msg,
  output logic                resp0_val,
  output logic [c_rs_sz-1:0]  resp0_msg,
  output logic                resp1_val,
  output logic [c_rs_sz-1:0]  resp1_msg,
  output logic                resp2_val,
  output logic [c_rs_sz-1:0]  resp2_msg,
  output logic                memreq_val,
  input  logic                memreq_rdy,
  output logic [c_rq_sz-1:0]  memreq_msg,
  input  logic                memresp_val,
  input  logic [c_rs_sz-1:0]  memresp_msg,
  output logic                memresp_rdy,
  output logic [c_cnt_sz-1:0] outstanding,
  output logic                err_orphan
);

  logic [1:0]          ptr_q, ptr_d;
  logic [c_ptr_sz-1:0] head_q, head_d, tail_q, tail_d;
  logic [c_cnt_sz-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [1:0]          tags_q [p_max_outstanding];

  logic [2:0] w_val;
  logic       w_can_grant, w_gnt, w_pop, w_orphan;
  logic [1:0] w_gnt_id, w_head_id;

  function automatic logic [1:0] f_mod3_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  assign w_val       = {req2_val, req1_val, req0_val};
  // Occupancy is sampled before any same-cycle pop, so a full FIFO blocks this cycle.
  assign w_can_grant = reset && memreq_rdy && (cnt_q < c_cnt_sz'(p_max_outstanding));

  always_comb begin
    w_gnt    = 1'b0;
    w_gnt_id = 2'd0;
    for (int k = 0; k < 3; k++) begin
      if (w_can_grant && !w_gnt && w_val[f_mod3_add(ptr_q, 2'(k))]) begin
        w_gnt    = 1'b1;
        w_gnt_id = f_mod3_add(ptr_q, 2'(k));
      end
    end
  end

  always_comb begin
    memreq_msg = req2_msg;
    case (w_gnt_id)
      2'd0:    memreq_msg = req0_msg;
      2'd1:    memreq_msg = req1_msg;
      default: memreq_msg = req2_msg;
    endcase
  end

  assign memreq_val = w_gnt;
  assign req0_rdy   = w_gnt && (w_gnt_id == 2'd0);
  assign req1_rdy   = w_gnt && (w_gnt_id == 2'd1);
  assign req2_rdy   = w_gnt && (w_gnt_id == 2'd2);

  assign w_head_id = tags_q[head_q];
  assign w_pop     = reset && memresp_val && (cnt_q != '0);
  assign w_orphan  = reset && memresp_val && (cnt_q == '0);

  assign memresp_rdy = reset;
  assign resp0_val   = w_pop && (w_head_id == 2'd0);
  assign resp1_val   = w_pop && (w_head_id == 2'd1);
  assign resp2_val   = w_pop && (w_head_id == 2'd2);
  assign resp0_msg   = memresp_msg;
  assign resp1_msg   = memresp_msg;
  assign resp2_msg   = memresp_msg;
  assign outstanding = cnt_q;
  assign err_orphan  = err_q;

  always_comb begin
    ptr_d  = ptr_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    err_d  = err_q | w_orphan;
    if (w_gnt) begin
      ptr_d  = f_mod3_add(w_gnt_id, 2'd1);
      tail_d = tail_q + c_ptr_sz'(1);
    end
    if (w_pop) head_d = head_q + c_ptr_sz'(1);
    case ({w_gnt, w_pop})
      2'b10:   cnt_d = cnt_q + c_cnt_sz'(1);
      2'b01:   cnt_d = cnt_q - c_cnt_sz'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  // Tag storage needs no reset: entries are only read while the count says they are valid.
  always_ff @(posedge clk) begin
    if (w_gnt) tags_q[tail_q] <= w_gnt_id;
  end

endmodule

`default_nettype wire

// File: tb/tb_parc_mem_arb3.sv
// tb_parc_mem_arb3: directed vectors for arbitration order, full FIFO, routing,
// backpressure, orphan responses and mid-flight reset.
`default_nettype none

module tb_parc_mem_arb3;

  localparam logic [66:0] c_m0 = 67'h1_2345_6789_0000_10A0;
  localparam logic [66:0] c_m1 = 67'h2_0000_0000_ABCD_20B1;
  localparam logic [66:0] c_m2 = 67'h4_FFFF_0000_1111_30C2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_val, req1_val, req2_val;
  logic        req0_rdy, req1_rdy, req2_rdy;
  logic [66:0] req0_msg, req1_msg, req2_msg;
  logic        resp0_val, resp1_val, resp2_val;
  logic [34:0] resp0_msg, resp1_msg, resp2_msg;
  logic        memreq_val, memreq_rdy;
  logic [66:0] memreq_msg;
  logic        memresp_val, memresp_rdy;
  logic [34:0] memresp_msg;
  logic [2:0]  outstanding;
  logic        err_orphan;

  int n_cmp = 0;
  int n_bad = 0;

  wire [2:0] rdyv  = {req2_rdy, req1_rdy, req0_rdy};
  wire [2:0] respv = {resp2_val, resp1_val, resp0_val};

  parc_mem_arb3 dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
    .req2_val(req2_val), .req2_rdy(req2_rdy), .req2_msg(req2_msg),
    .resp0_val(resp0_val), .resp0_msg(resp0_msg),
    .resp1_val(resp1_val), .resp1_msg(resp1_msg),
    .resp2_val(resp2_val), .resp2_msg(resp2_msg),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
    .memresp_val(memresp_val), .memresp_msg(memresp_msg), .memresp_rdy(memresp_rdy),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [66:0] got, input logic [66:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [66:0] exp_msg(input int n);
    return (n == 0) ? c_m0 : (n == 1) ? c_m1 : c_m2;
  endfunction

  task automatic set_vals(input logic [2:0] v);
    {req2_val, req1_val, req0_val} = v;
  endtask

  initial begin
    reset = 1'b0; memreq_rdy = 1'b1; memresp_val = 1'b1; memresp_msg = 35'h0;
    req0_msg = c_m0; req1_msg = c_m1; req2_msg = c_m2;
    set_vals(3'b111);
    cyc(); cyc();
    check_eq("rst_rdy", 67'(rdyv), 67'd0);
    check_eq("rst_memreq_val", 67'(memreq_val), 67'd0);
    check_eq("rst_memresp_rdy", 67'(memresp_rdy), 67'd0);
    check_eq("rst_respv", 67'(respv), 67'd0);
    check_eq("rst_outstanding", 67'(outstanding), 67'd0);
    check_eq("rst_err", 67'(err_orphan), 67'd0);

    // Fairness with memory latency of one cycle
    reset = 1'b1; memresp_val = 1'b0;
    for (int i = 0; i < 6; i++) begin
      memresp_val = (i > 0);
      memresp_msg = 35'(32'h100 + i);
      #1;
      check_eq("fair_rdy", 67'(rdyv), 67'(3'b001 << (i % 3)));
      check_eq("fair_msg", memreq_msg, exp_msg(i % 3));
      check_eq("fair_respv", 67'(respv), (i == 0) ? 67'd0 : 67'(3'b001 << ((i - 1) % 3)));
      check_eq("fair_out", 67'(outstanding), (i == 0) ? 67'd0 : 67'd1);
      cyc();
    end
    set_vals(3'b000); memresp_val = 1'b1; #1;
    check_eq("fair_last_resp", 67'(respv), 67'd4);
    cyc(); memresp_val = 1'b0; #1;
    check_eq("fair_drained", 67'(outstanding), 67'd0);

    // Fill the tag FIFO from port 2
    set_vals(3'b100);
    for (int i = 0; i < 4; i++) begin
      #1; check_eq("full_grant", 67'(rdyv), 67'd4); cyc();
    end
    #1;
    check_eq("full_rdy", 67'(rdyv), 67'd0);
    check_eq("full_out", 67'(outstanding), 67'd4);
    check_eq("full_memreq_val", 67'(memreq_val), 67'd0);
    memresp_val = 1'b1; memresp_msg = 35'h55; #1;
    check_eq("full_pop_respv", 67'(respv), 67'd4);
    check_eq("full_pop_msg", 67'(resp2_msg), 67'h55);
    check_eq("full_pop_nogrant", 67'(memreq_val), 67'd0);
    cyc(); memresp_val = 1'b0; #1;
    check_eq("full_after_pop_out", 67'(outstanding), 67'd3);
    check_eq("full_after_pop_grant", 67'(rdyv), 67'd4);
    cyc(); set_vals(3'b000); #1;
    check_eq("full_refill", 67'(outstanding), 67'd4);
    memresp_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      memresp_msg = 35'(i); #1;
      check_eq("full_drain_respv", 67'(respv), 67'd4);
      cyc();
    end
    memresp_val = 1'b0; #1;
    check_eq("full_drained", 67'(outstanding), 67'd0);

    // Routing: grants 1,2,0 then responses A,B,C
    set_vals(3'b010); #1; check_eq("route_g1", 67'(rdyv), 67'd2); cyc();
    set_vals(3'b100); #1; check_eq("route_g2", 67'(rdyv), 67'd4); cyc();
    set_vals(3'b001); #1; check_eq("route_g0", 67'(rdyv), 67'd1); cyc();
    set_vals(3'b000); memresp_val = 1'b1;
    memresp_msg = 35'hA; #1;
    check_eq("route_respv_A", 67'(respv), 67'd2);
    check_eq("route_msg_A", 67'(resp1_msg), 67'hA);
    cyc(); memresp_msg = 35'hB; #1;
    check_eq("route_respv_B", 67'(respv), 67'd4);
    check_eq("route_msg_B", 67'(resp2_msg), 67'hB);
    cyc(); memresp_msg = 35'hC; #1;
    check_eq("route_respv_C", 67'(respv), 67'd1);
    check_eq("route_msg_C", 67'(resp0_msg), 67'hC);
    cyc(); memresp_val = 1'b0; #1;
    check_eq("route_drained", 67'(outstanding), 67'd0);

    // Backpressure: nothing granted, pointer (now 1) must hold
    memreq_rdy = 1'b0; set_vals(3'b001);
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("bp_rdy", 67'(rdyv), 67'd0);
      check_eq("bp_memreq_val", 67'(memreq_val), 67'd0);
      cyc();
    end
    memreq_rdy = 1'b1; #1;
    check_eq("bp_release_grant", 67'(rdyv), 67'd1);
    check_eq("bp_release_msg", memreq_msg, c_m0);
    cyc(); set_vals(3'b111); #1;
    check_eq("bp_ptr_is_1", 67'(rdyv), 67'd2);
    cyc(); set_vals(3'b000); memresp_val = 1'b1; #1;
    check_eq("bp_resp0", 67'(respv), 67'd1);
    cyc(); #1;
    check_eq("bp_resp1", 67'(respv), 67'd2);
    cyc(); memresp_val = 1'b0; #1;
    check_eq("bp_drained", 67'(outstanding), 67'd0);

    // Orphan response
    memresp_val = 1'b1; #1;
    check_eq("orph_respv", 67'(respv), 67'd0);
    check_eq("orph_memresp_rdy", 67'(memresp_rdy), 67'd1);
    check_eq("orph_err_before", 67'(err_orphan), 67'd0);
    cyc(); memresp_val = 1'b0; #1;
    check_eq("orph_err", 67'(err_orphan), 67'd1);
    check_eq("orph_out", 67'(outstanding), 67'd0);
    cyc(); cyc(); cyc();
    check_eq("orph_sticky", 67'(err_orphan), 67'd1);
    reset = 1'b0; cyc(); reset = 1'b1; #1;
    check_eq("orph_cleared", 67'(err_orphan), 67'd0);

    // Reset with three requests in flight
    set_vals(3'b010);
    cyc(); cyc(); cyc();
    check_eq("mid_out3", 67'(outstanding), 67'd3);
    set_vals(3'b000); reset = 1'b0; cyc(); reset = 1'b1; #1;
    check_eq("mid_out0", 67'(outstanding), 67'd0);
    memresp_val = 1'b1; #1;
    check_eq("mid_late_respv", 67'(respv), 67'd0);
    cyc(); memresp_val = 1'b0; #1;
    check_eq("mid_late_err", 67'(err_orphan), 67'd1);
    set_vals(3'b111); #1;
    check_eq("mid_ptr_zero", 67'(rdyv), 67'd1);
    cyc(); set_vals(3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/parc_mem_arb3.md
PARC_MEM_ARB3 -- requirements
Module: parc_mem_arb3

Interface
REQ-001 SHALL have parameter p_addr_sz, default 32, the request address width.
REQ-002 SHALL have parameter p_data_sz, default 32, the request and response data width.
REQ-003 SHALL have parameter p_max_outstanding, default 4, the routing-tag FIFO depth; legal values are powers of two from 2 to 16.
REQ-004 Widths: RQ = VC_MEM_REQ_MSG_SZ(p_addr_sz,p_data_sz); RS = VC_MEM_RESP_MSG_SZ(p_data_sz).
REQ-005 clk  in  1  clock, rising edge.
REQ-006 reset  in  1  reset, synchronous, active-low.
REQ-007 For n = 0,1,2: reqN_val in 1; reqN_rdy out 1; reqN_msg in RQ. Port 0 is imem0, port 1 is imem1, port 2 is dmem.
REQ-008 For n = 0,1,2: respN_val out 1; respN_msg out RS. There is no ready; requesters always accept a response.
REQ-009 memreq_val out 1; memreq_rdy in 1; memreq_msg out RQ. This is the single downstream memory request port.
REQ-010 memresp_val in 1; memresp_msg in RS; memresp_rdy out 1. Downstream responses return in request order.
REQ-011 outstanding  out  clog2(p_max_outstanding)+1  number of in-flight requests.
REQ-012 err_orphan  out  1  sticky flag: a response arrived with no request outstanding.

Function
REQ-013 SHALL share one downstream port among three requesters, with round-robin arbitration and in-order response routing.
REQ-014 Eligibility: requester n is eligible when reqN_val=1.
- Grant is possible when reset=1, memreq_rdy=1 and outstanding < p_max_outstanding.
- A pop in the same cycle does NOT free space for that cycle.
REQ-015 Arbitration is combinational within the cycle.
- Priority order is ptr, ptr+1, ptr+2 (mod 3), where ptr is a 2-bit register.
- At most one grant per cycle.
REQ-016 Granted port g: memreq_val=1, memreq_msg=reqg_msg, reqg_rdy=1.
- All other reqN_rdy=0.
- With no grant: memreq_val=0 and all reqN_rdy=0.
REQ-017 memreq_val SHALL NOT depend on memreq_rdy being sampled in a prior cycle; the handshake completes in the same cycle as val and rdy.
REQ-018 On a completed grant to port g:
- ptr <= (g+1) mod 3 at the next edge.
- Port id g is pushed into the tag FIFO.
- With no grant, ptr holds.
REQ-019 Tag FIFO: circular buffer of p_max_outstanding 2-bit entries with head and tail pointers.
- Pointers wrap modulo the depth.
- outstanding SHALL equal the occupancy.
REQ-020 memresp_rdy SHALL be 1 whenever reset=1.
REQ-021 When memresp_val=1 and outstanding > 0:
- respH_val=1 and respH_msg=memresp_msg in the same cycle, where H is the FIFO head id.
- The head is popped at the next edge.
- The other respN_val=0.
REQ-022 When memresp_val=1 and outstanding = 0:
- The response is dropped and no respN_val is asserted.
- err_orphan <= 1 at the next edge and holds until reset.
REQ-023 Push and pop in the same cycle: both take effect and outstanding is unchanged.
REQ-024 A response may return in the same cycle as its grant only if outstanding was already > 0 for an earlier request. Zero-latency response to the current grant is not supported and counts as orphan when the FIFO is empty.
REQ-025 respN_msg SHALL be driven with memresp_msg on all ports at all times; only the val signals are gated.
REQ-026 Throughput: with memreq_rdy=1 and responses keeping pace, one grant per cycle is sustained.

Reset
REQ-027 When reset=0 at a rising edge:
- ptr <= 0.
- FIFO head, tail and count <= 0.
- err_orphan <= 0.
REQ-028 While reset=0, all reqN_rdy, memreq_val, respN_val and memresp_rdy SHALL be 0.
REQ-029 Reset mid-operation discards all tags. Responses to requests in flight before reset and returning after it are orphans: they set err_orphan and are not routed.

Verification
REQ-030 Fairness: all three val=1 continuously, memreq_rdy=1, memory latency 1, depth 4 -> grant order 0,1,2,0,1,2; outstanding never exceeds 1.
REQ-031 Full: memreq_rdy=1 and no responses, port 2 valid -> 4 grants; then reqN_rdy=0 and outstanding=4. One response then -> resp2_val=1 and outstanding=3; the next grant occurs one cycle after the pop.
REQ-032 Routing: grant sequence 1,2,0 with responses data 0xA,0xB,0xC -> resp1=0xA, resp2=0xB, resp0=0xC, each with the other vals low.
REQ-033 Backpressure: memreq_rdy=0 for 5 cycles with port 0 valid -> no grant and ptr unchanged; rdy=1 -> port 0 granted and ptr=1.
REQ-034 Orphan: memresp_val=1 with outstanding=0 -> no respN_val and err_orphan=1 next cycle, sticky until reset=0.
REQ-035 Reset mid-flight: 3 outstanding, reset=0 for one cycle -> outstanding=0 and ptr=0; a late response sets err_orphan.
